// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit for the EX stage: owns HI/LO, computes the
// result at the start edge, holds it pending, and commits after a fixed latency.
module mdu_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  output logic        busy,
  output logic [3:0]  tnew,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8,
    OP_MTHI  = 4'd9,
    OP_MTLO  = 4'd10
  } op_e;

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] ph_q, ph_d;
  logic [31:0] pl_q, pl_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dz_q, dz_d;

  logic        busy_w;
  logic        op_legal;
  logic        go;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [63:0] acc;

  logic        div_sgn;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_raw;
  logic [31:0] dvs_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  assign busy_w   = (cnt_q != 4'd0);
  assign op_legal = (op >= 4'd1) && (op <= 4'd10);
  assign go       = start && !req && !busy_w && op_legal;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign acc    = {hi_q, lo_q};

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to
  // 0x80000000 rem 0; a zero divisor is replaced by 1 since its result is never committed.
  assign div_sgn = (op == OP_DIV);
  assign dvd_mag = (div_sgn && a[31]) ? 32'd0 - a : a;
  assign dvs_raw = (div_sgn && b[31]) ? 32'd0 - b : b;
  assign dvs_mag = (dvs_raw == 32'd0) ? 32'd1 : dvs_raw;
  assign q_mag   = dvd_mag / dvs_mag;
  assign r_mag   = dvd_mag % dvs_mag;
  assign quo     = (div_sgn && (a[31] ^ b[31])) ? 32'd0 - q_mag : q_mag;
  assign rem     = (div_sgn && a[31]) ? 32'd0 - r_mag : r_mag;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    ph_d  = ph_q;
    pl_d  = pl_q;
    cnt_d = cnt_q;
    dz_d  = dz_q;

    if (busy_w) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1 && !dz_q) begin
        hi_d = ph_q;
        lo_d = pl_q;
      end
    end else if (go) begin
      dz_d = 1'b0;
      case (op)
        OP_MULT: begin
          {ph_d, pl_d} = prod_s;
          cnt_d        = 4'(MULT_LAT);
        end
        OP_MULTU: begin
          {ph_d, pl_d} = prod_u;
          cnt_d        = 4'(MULT_LAT);
        end
        OP_MADD: begin
          {ph_d, pl_d} = acc + prod_s;
          cnt_d        = 4'(MULT_LAT);
        end
        OP_MADDU: begin
          {ph_d, pl_d} = acc + prod_u;
          cnt_d        = 4'(MULT_LAT);
        end
        OP_MSUB: begin
          {ph_d, pl_d} = acc - prod_s;
          cnt_d        = 4'(MULT_LAT);
        end
        OP_MSUBU: begin
          {ph_d, pl_d} = acc - prod_u;
          cnt_d        = 4'(MULT_LAT);
        end
        OP_DIV, OP_DIVU: begin
          ph_d  = rem;
          pl_d  = quo;
          dz_d  = (b == 32'd0);
          cnt_d = 4'(DIV_LAT);
        end
        OP_MTHI: hi_d = a;
        OP_MTLO: lo_d = a;
        default: ;
      endcase
    end
  end

  // NOTE: reset is sampled on the clock edge (synchronous, active-low) and clears the pending
  // result too, so an abandoned operation can never commit later.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so all of them update together at the edge.
    if (!reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      ph_q  <= '0;
      pl_q  <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      ph_q  <= ph_d;
      pl_q  <= pl_d;
      cnt_q <= cnt_d;
      dz_q  <= dz_d;
    end
  end

  assign busy = busy_w;
  assign tnew = cnt_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus pushes expected HI/LO and commit cycle,
// a monitor pops and compares whenever busy falls.
module tb_mdu_unit;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        busy;
  logic [3:0]  tnew;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .req   (req),
    .busy  (busy),
    .tnew  (tnew),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   mon_en  = 0;
  bit   busy_prev = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a falling busy is the DUT presenting a committed result.
  always @(negedge clk) begin
    if (mon_en && busy_prev && !busy) begin
      if (sb.size() == 0) begin
        check("unexpected_commit", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
        check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
        check({e.name, "_cyc"}, 64'(cyc), 64'(e.cyc));
      end
    end
    busy_prev = busy;
  end

  // All tasks begin and end just after a falling edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic r);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    req   = r;
    @(negedge clk);
    start = 1'b0;
    op    = 4'd0;
    req   = 1'b0;
  endtask

  task automatic expect_commit(input string name, input logic [31:0] h, input logic [31:0] l,
                               input int lat);
    exp_t e;
    e.name = name;
    e.hi   = h;
    e.lo   = l;
    e.cyc  = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 4'd0;
    a     = '0;
    b     = '0;
    req   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tnew", 64'(tnew), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Signed mult -3 * 7 with tnew countdown; HI/LO unchanged until the last edge
    issue(4'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
    expect_commit("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, MULT_LAT);
    for (int k = MULT_LAT; k >= 1; k--) begin
      check("mult_busy", 64'(busy), 64'd1);
      check("mult_tnew", 64'(tnew), 64'(k));
      check("mult_hold", {hi, lo}, 64'd0);
      @(negedge clk);
    end
    check("mult_done_busy", 64'(busy), 64'd0);

    issue(4'd4, 32'd100, 32'd7, 1'b0);
    expect_commit("divu", 32'd2, 32'd14, DIV_LAT);
    wait_idle("divu");

    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    expect_commit("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    wait_idle("div_neg");

    // mthi/mtlo commit at their own edge with no busy cycle
    issue(4'd9, 32'd0, 32'd0, 1'b0);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_hi", 64'(hi), 64'd0);
    issue(4'd10, 32'hFFFF_FFFF, 32'd0, 1'b0);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_lo", 64'(lo), 64'hFFFF_FFFF);

    issue(4'd6, 32'd1, 32'd1, 1'b0);
    expect_commit("maddu", 32'd1, 32'd0, MULT_LAT);
    wait_idle("maddu");

    issue(4'd7, 32'd2, 32'd3, 1'b0);
    expect_commit("msub", 32'd0, 32'hFFFF_FFFA, MULT_LAT);
    wait_idle("msub");

    // Start suppressed by req
    issue(4'd1, 32'd5, 32'd5, 1'b1);
    check("req_busy", 64'(busy), 64'd0);
    check("req_hilo", {hi, lo}, {32'd0, 32'hFFFF_FFFA});

    // Div issued while a mult is in flight is ignored
    issue(4'd1, 32'h0001_0000, 32'h0001_0000, 1'b0);
    expect_commit("overlap_mult", 32'd1, 32'd0, MULT_LAT);
    @(negedge clk);
    issue(4'd3, 32'd9, 32'd3, 1'b0);
    wait_idle("overlap");
    repeat (DIV_LAT + 2) @(negedge clk);
    check("overlap_busy", 64'(busy), 64'd0);
    check("overlap_hilo", {hi, lo}, {32'd1, 32'd0});

    // Divide by zero: full latency, no commit
    issue(4'd9, 32'h11, 32'd0, 1'b0);
    issue(4'd10, 32'h22, 32'd0, 1'b0);
    issue(4'd3, 32'd5, 32'd0, 1'b0);
    expect_commit("div_zero", 32'h11, 32'h22, DIV_LAT);
    wait_idle("div_zero");

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    expect_commit("div_ovf", 32'd0, 32'h8000_0000, DIV_LAT);
    wait_idle("div_ovf");

    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    expect_commit("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, MULT_LAT);
    wait_idle("multu_max");

    // Reset mid-op abandons the mult
    issue(4'd1, 32'd6, 32'd7, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    expect_commit("rst_mid", 32'd0, 32'd0, 1);
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_tnew", 64'(tnew), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    repeat (MULT_LAT + 3) @(negedge clk);
    check("rst_no_late_busy", 64'(busy), 64'd0);
    check("rst_no_late_hilo", {hi, lo}, 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the P7 pipeline.
- Owns the architectural HI/LO registers and executes mult/multu/div/divu/madd/maddu/msub/msubu/mthi/mtlo.
- Produces `busy`/`tnew`, which the stall controller reads alongside its start strobe (`start`) to stall MD-class instructions in D.
- HI/LO read values feed the EX result mux for mfhi/mflo.

Parameters:
- MULT_LAT, 5, cycles from start edge to HI/LO commit for mult/multu/madd/maddu/msub/msubu (legal range 1..15).
- DIV_LAT, 10, cycles from start edge to HI/LO commit for div/divu (legal range 1..15).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-low reset: state clears on a rising clk edge while reset==0.
- start  in  1  EX instruction is an MD op (enMDU); sampled on the rising edge.
- op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu, 9 mthi, 10 mtlo; 11-15 treated as none.
- a  in  32  forwarded rs value.
- b  in  32  forwarded rt value.
- req  in  1  exception/interrupt request at M; when high, suppresses any start in the same cycle.
- busy  out  1  an operation is in flight (cnt != 0).
- tnew  out  4  cycles remaining until HI/LO hold the result (equals cnt).
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-low.
- Reset (reset==0 at edge): hi=0, lo=0, cnt=0, pending regs=0, so busy=0 and tnew=0. An in-flight operation is abandoned and never commits.
- Accept condition: `go = start & ~req & ~busy & op in 1..10`. If start is high but any other term fails, the request is ignored and no state changes.
- mthi/mtlo on go: hi<=a (or lo<=a) at that same edge. cnt stays 0; no busy cycle.
- mult/multu on go:
  - Pending {ph,pl} <= 64-bit product of a, b, signed or unsigned respectively.
  - cnt <= MULT_LAT.
- madd/maddu/msub/msubu on go:
  - Pending <= {hi,lo} ± product (signed/unsigned per op), computed with the hi/lo values at the start edge.
  - Arithmetic is mod 2^64; there is no overflow trap.
  - cnt <= MULT_LAT.
- div/divu on go:
  - Pending pl = quotient, ph = remainder, signed or unsigned.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
  - b==0: the op still occupies DIV_LAT cycles, but at completion hi/lo are left unchanged (the commit is skipped).
  - cnt <= DIV_LAT.
- Countdown: while cnt != 0, cnt decrements by 1 each edge. On the edge where cnt goes 1→0, {hi,lo} <= pending (unless a divide-by-zero skip applies).
- Cycle timing: with start at edge T, busy is high for cycles T+1 .. T+LAT, and new hi/lo are visible from cycle T+LAT onward after that edge.
- No early completion.
- Outputs:
  - busy and tnew are registered-state derived, with no combinational path from start.
  - hi and lo are the committed registers only; pending values are never visible.
- The pending result may be computed combinationally at the start edge or with an iterative datapath. Only the commit timing and the final values are specified.
- req is only sampled at start. Once accepted, an op always completes; an exception arriving later does not cancel it.
- Simultaneous reset and start: reset wins.

Test Plan:
- Signed mult: reset, then a=0xFFFFFFFD (-3), b=7, op=1, start for 1 cycle → busy=1 and tnew=5,4,3,2,1 on successive cycles; then busy=0, hi=0xFFFFFFFF, lo=0xFFFFFFEB; hi/lo stay 0 until the final edge.
- divu: a=100, b=7, op=4 → after exactly 10 cycles lo=14, hi=2. Then div: a=0xFFFFFFF9 (-7), b=2, op=3 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Accumulate: mthi 0, mtlo 0xFFFFFFFF (each commits at its start edge with no busy cycle), then maddu a=1, b=1 → hi=1, lo=0. Then msub a=2, b=3 → {hi,lo}=0x00000000_FFFFFFFA.
- Suppression and overlap:
  - start with op=1 while req=1 → busy stays 0, hi/lo unchanged.
  - start with op=3 while busy from a prior mult → ignored; the mult result commits on schedule.
- Divide by zero: hi=0x11, lo=0x22, div a=5, b=0 → busy for 10 cycles, then hi=0x11, lo=0x22.
- Reset mid-op: mult 6×7; drive reset=0 on cycle 3 → next edge busy=0, tnew=0, hi=lo=0. No late commit occurs after release.
